// File: rtl/updown_mod_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : updown_mod_counter_pkg
// Brief    : Direction encodings and modulus helper shared with timer blocks.
// Revision : 1.0 - initial release
// ============================================================================
package updown_mod_counter_pkg;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } dir_e;

    // Largest count representable in a counter of the given width.
    function automatic int max_for_width(input int width);
        return (1 << width) - 1;
    endfunction

endpackage : updown_mod_counter_pkg
`default_nettype wire

// File: rtl/updown_mod_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : updown_mod_counter_if
// Brief    : Control and status bundle between a counter and its user.
// Revision : 1.0 - initial release
// ============================================================================
interface updown_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;

    modport master (
        output en,
        output up,
        output load,
        output load_val,
        input  q,
        input  tc,
        input  wrap
    );

    modport slave (
        input  en,
        input  up,
        input  load,
        input  load_val,
        output q,
        output tc,
        output wrap
    );
endinterface : updown_mod_counter_if
`default_nettype wire

// File: rtl/updown_mod_counter_inc_dec_unit.sv
`default_nettype none
// ============================================================================
// Module   : inc_dec_unit
// Brief    : Combinational +/-1 ripple chain with direction-aware boundary flag.
// Revision : 1.0 - initial release
// ============================================================================
module inc_dec_unit
    import updown_mod_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  wire logic [WIDTH-1:0] a,
    input  wire logic             up,
    input  wire logic [WIDTH-1:0] max_val,
    output logic      [WIDTH-1:0] next,
    output logic                  boundary
);

    logic [WIDTH-1:0] w_carry;

    assign w_carry[0] = 1'b1;

    // A bit toggles when every lower bit is 1 (increment) or 0 (decrement),
    // so one chain serves as both half-adder and half-subtractor.
    for (genvar i = 1; i < WIDTH; i++) begin : g_carry
        assign w_carry[i] = ((up == DIR_UP) ? a[i-1] : ~a[i-1]) & w_carry[i-1];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_sum
        assign next[i] = a[i] ^ w_carry[i];
    end

    assign boundary = (up == DIR_UP) ? (a == max_val) : (a == '0);

endmodule : inc_dec_unit
`default_nettype wire

// File: rtl/updown_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : updown_mod_counter
// Brief    : Loadable up/down modulo-(MAX_VAL+1) counter with tc and wrap.
//            Define COUNTER_SATURATE_EN to hold at the boundary instead of wrap.
// Revision : 1.0 - initial release
// ============================================================================
module updown_mod_counter
    import updown_mod_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = max_for_width(WIDTH)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    updown_mod_counter_if.slave   bus
);

    localparam logic [WIDTH-1:0] c_max_q = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_load_clamped;
    logic             w_boundary;

    inc_dec_unit #(
        .WIDTH    (WIDTH)
    ) u_inc_dec (
        .a        (r_q),
        .up       (bus.up),
        .max_val  (c_max_q),
        .next     (w_step),
        .boundary (w_boundary)
    );

    // Loads above the modulus clamp so out-of-range states are unreachable.
    assign w_load_clamped = (bus.load_val > c_max_q) ? c_max_q : bus.load_val;

`ifdef COUNTER_SATURATE_EN
    always_comb begin
        w_q_next = r_q;
        if (bus.load) begin
            w_q_next = w_load_clamped;
        end else if (bus.en && !w_boundary) begin
            w_q_next = w_step;
        end
    end

    assign bus.wrap = 1'b0;
`else
    logic r_wrap;
    logic w_wrap_next;

    always_comb begin
        w_q_next    = r_q;
        w_wrap_next = 1'b0;
        if (bus.load) begin
            w_q_next = w_load_clamped;
        end else if (bus.en) begin
            if (w_boundary) begin
                w_q_next    = (bus.up == DIR_UP) ? '0 : c_max_q;
                w_wrap_next = 1'b1;
            end else begin
                w_q_next = w_step;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_next;
        end
    end

    assign bus.wrap = r_wrap;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign bus.q  = r_q;
    // Boundary flag of the current state doubles as terminal count.
    assign bus.tc = w_boundary;

endmodule : updown_mod_counter
`default_nettype wire

// File: tb/tb_updown_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_updown_mod_counter
// Brief    : Directed and random checks of updown_mod_counter (WIDTH=4, MAX_VAL=9).
// Revision : 1.0 - initial release
// ============================================================================
module tb_updown_mod_counter;

    localparam int WIDTH   = 4;
    localparam int MAX_VAL = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    updown_mod_counter_if #(.WIDTH(WIDTH)) bus ();

    updown_mod_counter #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_mis  = 0;
    int m_q    = 0;
    int m_wrap = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_tc(input int q, input bit u);
        return ((u && q == MAX_VAL) || (!u && q == 0)) ? 1 : 0;
    endfunction

    // One clock: drive at negedge, check tc, then check registered state after the edge.
    task automatic cyc(input bit r, input bit e, input bit u, input bit l, input int lv);
        @(negedge clk);
        rst          = r;
        bus.en       = e;
        bus.up       = u;
        bus.load     = l;
        bus.load_val = WIDTH'(lv);
        #1 check("tc", int'(bus.tc), exp_tc(m_q, u));
        @(posedge clk);
        if (r) begin
            m_q    = 0;
            m_wrap = 0;
        end else if (l) begin
            m_q    = (lv > MAX_VAL) ? MAX_VAL : lv;
            m_wrap = 0;
        end else if (e) begin
`ifdef COUNTER_SATURATE_EN
            m_q    = u ? ((m_q < MAX_VAL) ? m_q + 1 : MAX_VAL) : ((m_q > 0) ? m_q - 1 : 0);
            m_wrap = 0;
`else
            m_wrap = (u && m_q == MAX_VAL) || (!u && m_q == 0) ? 1 : 0;
            m_q    = u ? (m_q + 1) % (MAX_VAL + 1) : (m_q + MAX_VAL) % (MAX_VAL + 1);
`endif
        end else begin
            m_wrap = 0;
        end
        #1;
        check("q", int'(bus.q), m_q);
        check("wrap", int'(bus.wrap), m_wrap);
    endtask

    initial begin
        bus.en       = 1'b0;
        bus.up       = 1'b1;
        bus.load     = 1'b0;
        bus.load_val = '0;

        cyc(1, 1, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);

        // tc follows up combinationally at q=0
        @(negedge clk);
        rst    = 1'b0;
        bus.en = 1'b0;
        bus.up = 1'b1;
        #1 check("tc_dir_up", int'(bus.tc), exp_tc(m_q, 1'b1));
        bus.up = 1'b0;
        #1 check("tc_dir_dn", int'(bus.tc), exp_tc(m_q, 1'b0));

        // count up through a wrap
        for (int i = 0; i < 12; i++) cyc(0, 1, 1, 0, 0);

        // load 3, count down through a wrap
        cyc(0, 0, 0, 1, 3);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);

        // clamped load, then up count at the top
        cyc(0, 0, 1, 1, 14);
        cyc(0, 1, 1, 0, 0);

        // load beats boundary on the same edge
        cyc(0, 0, 1, 1, 9);
        cyc(0, 1, 1, 1, 5);

        // reset mid-count
        cyc(0, 1, 1, 0, 0);
        cyc(1, 1, 1, 1, 7);
        cyc(0, 0, 1, 0, 0);

        // saturate-style scenarios (wrap in default build)
        cyc(0, 0, 1, 1, 7);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);

        // random mix
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 31) == 0),
                ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0),
                int'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_updown_mod_counter
`default_nettype wire
